// File: rtl/dclk_tx_pkg.sv
// Shared link definitions for the dclk transmitter/receiver pair: flit field sizes and the
// two-bit link state codes that both ends use.
package dclk_tx_pkg;

  localparam int unsigned HDR_SZ  = 2;
  localparam int unsigned PL_SZ   = 4;
  localparam int unsigned ADDR_SZ = 2;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StSend     = 2'd1,
    StWaitAck  = 2'd2,
    StWaitFree = 2'd3
  } link_state_e;

endpackage

// File: rtl/dclk_sync2.sv
// Two-flop synchroniser with synchronous active-high reset; q follows din two clk edges later.
module dclk_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= din;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/dclk_tx.sv
// Serialising link transmitter: start bit '1', FLIT_W payload bits LSB-first, then idle '0',
// throttled by the receiver's synchronised busy. Define DCLK_TX_STATS_EN for frame/stall counters.
module dclk_tx
  import dclk_tx_pkg::*;
#(
  parameter int unsigned FLIT_W = HDR_SZ + PL_SZ + ADDR_SZ,
  parameter string       port   = "unknown"
) (
  input  logic              rclk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] item_in,
  input  logic              item_valid,
  output logic              item_ready,
  input  logic              channel_busy,
  output logic              serial_out,
  output logic              tx_busy
`ifdef DCLK_TX_STATS_EN
  ,
  output logic [15:0]       frames_sent,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int unsigned CntW = $clog2(FLIT_W) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(FLIT_W - 1);

  // The label only names the instance in debug views; it has no hardware effect.
  if (port == "") begin : g_unlabeled
  end

  link_state_e       state_q;
  logic [FLIT_W-1:0] shift_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_s;

  dclk_sync2 u_busy_sync (
    .clk   (rclk),
    .reset (reset),
    .din   (channel_busy),
    .q     (busy_s)
  );

  assign item_ready = (state_q == StIdle) && !busy_s;
  assign tx_busy    = (state_q != StIdle);

  always_ff @(posedge rclk) begin
    if (reset) begin
      state_q    <= StIdle;
      serial_out <= 1'b0;
      shift_q    <= '0;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          serial_out <= 1'b0;
          if (item_valid && item_ready) begin
            shift_q    <= item_in;
            cnt_q      <= '0;
            serial_out <= 1'b1;
            state_q    <= StSend;
          end
        end
        StSend: begin
          serial_out <= shift_q[0];
          shift_q    <= shift_q >> 1;
          cnt_q      <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) state_q <= StWaitAck;
        end
        // The receiver raises busy on the start bit, so this normally passes straight through.
        StWaitAck: begin
          serial_out <= 1'b0;
          if (busy_s) state_q <= StWaitFree;
        end
        StWaitFree: begin
          serial_out <= 1'b0;
          if (!busy_s) state_q <= StIdle;
        end
        default: begin
          serial_out <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

`ifdef DCLK_TX_STATS_EN
  always_ff @(posedge rclk) begin
    if (reset) begin
      frames_sent  <= '0;
      stall_cycles <= '0;
    end else begin
      if (state_q == StSend && cnt_q == LastCnt) frames_sent <= frames_sent + 16'd1;
      if (item_valid && !item_ready) stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dclk_tx.sv
// Scoreboard bench for dclk_tx: stimulus pushes accepted flits, a monitor deserialises the line,
// models the receiver's busy handshake and compares each frame against the queue.
module tb_dclk_tx;

  localparam int unsigned FW = 8;

  logic          rclk = 1'b0;
  logic          reset = 1'b1;
  logic [FW-1:0] item_in = '0;
  logic          item_valid = 1'b0;
  logic          item_ready;
  logic          channel_busy = 1'b0;
  logic          serial_out;
  logic          tx_busy;
`ifdef DCLK_TX_STATS_EN
  logic [15:0]   frames_sent;
  logic [15:0]   stall_cycles;
`endif

  dclk_tx #(
    .FLIT_W (FW),
    .port   ("tb")
  ) dut (
    .rclk         (rclk),
    .reset        (reset),
    .item_in      (item_in),
    .item_valid   (item_valid),
    .item_ready   (item_ready),
    .channel_busy (channel_busy),
    .serial_out   (serial_out),
    .tx_busy      (tx_busy)
`ifdef DCLK_TX_STATS_EN
    ,
    .frames_sent  (frames_sent),
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 rclk = ~rclk;

  int unsigned   n_pass = 0;
  int unsigned   n_total = 0;
  logic [FW-1:0] sb[$];
  bit            ack_en = 1'b0;
  time           fall_t = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Receiver model: busy on the start bit, released three cycles after the last payload bit.
  initial begin
    bit            cap_active = 1'b0;
    int            bitn = 0;
    int            hold = 0;
    logic [FW-1:0] cap = '0;
    logic [FW-1:0] exp;
    forever begin
      @(posedge rclk);
      #1;
      if (reset) begin
        if (cap_active && sb.size() > 0) void'(sb.pop_front());
        cap_active = 1'b0;
        hold = 0;
        if (ack_en) channel_busy = 1'b0;
      end else begin
        if (hold > 0) begin
          hold--;
          if (hold == 0 && ack_en) begin
            channel_busy = 1'b0;
            fall_t = $time;
          end
        end
        if (cap_active) begin
          cap[bitn] = serial_out;
          bitn++;
          if (bitn == FW) begin
            cap_active = 1'b0;
            hold = 3;
            if (sb.size() == 0) check("frame_unexpected", {24'd0, cap}, 32'hDEAD);
            else begin
              exp = sb.pop_front();
              check("frame", {24'd0, cap}, {24'd0, exp});
            end
          end
        end else if (serial_out) begin
          cap_active = 1'b1;
          bitn = 0;
          if (ack_en) channel_busy = 1'b1;
        end
      end
    end
  end

  // Returns at posedge+1 of the accept edge.
  task automatic send(input logic [FW-1:0] d, output time acc_t);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge rclk);
      if (item_ready) break;
    end
    if (i == 200) check("ready_timeout", 0, 1);
    item_in = d;
    item_valid = 1'b1;
    sb.push_back(d);
    acc_t = $time + 5;
    @(posedge rclk);
    #1;
    item_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge rclk);
      if (!tx_busy) break;
    end
    if (i == 100) check("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge rclk);
    reset = 1'b1;
    repeat (3) @(negedge rclk);
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    time       t;
    time       t2;
    bit        seen_r;
    bit        seen_s;
    logic [9:0] exp_line;

    // Reset state
    do_reset();
    @(negedge rclk);
    check("rst_serial", {31'd0, serial_out}, 0);
    check("rst_tx_busy", {31'd0, tx_busy}, 0);
    check("rst_ready", {31'd0, item_ready}, 1);

    // 0xA5 with no receiver ack: exact line pattern, then parked in WAIT_ACK
    ack_en = 1'b0;
    exp_line = 10'b0_1010_0101_1;  // bit0 first: start, d0..d7, idle
    send(8'hA5, t);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        @(posedge rclk);
        #1;
      end
      check($sformatf("a5_bit%0d", k), {31'd0, serial_out}, {31'd0, exp_line[k]});
    end
    repeat (3) @(posedge rclk);
    #1;
    check("waitack_busy", {31'd0, tx_busy}, 1);
    check("waitack_ready", {31'd0, item_ready}, 0);
    @(negedge rclk);
    channel_busy = 1'b1;
    repeat (4) @(negedge rclk);
    channel_busy = 1'b0;
    repeat (5) @(negedge rclk);
    check("freed_busy", {31'd0, tx_busy}, 0);

    // Back-to-back frames through the receiver model
    ack_en = 1'b1;
    repeat (2) @(negedge rclk);
    send(8'h3C, t);
    send(8'hFF, t2);
    check("second_after_free", {31'd0, (t2 > fall_t + 20) ? 1'b1 : 1'b0}, 1);
    wait_idle();

    // Held channel_busy: nothing accepted, line stays low
    ack_en = 1'b0;
    repeat (5) @(negedge rclk);
    channel_busy = 1'b1;
    do_reset();
    repeat (2) @(negedge rclk);  // synchroniser latency after release
    item_in = 8'h77;
    item_valid = 1'b1;
    seen_r = 1'b0;
    seen_s = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge rclk);
      #1;
      if (item_ready) seen_r = 1'b1;
      if (serial_out) seen_s = 1'b1;
    end
    item_valid = 1'b0;
    check("held_ready", {31'd0, seen_r}, 0);
    check("held_serial", {31'd0, seen_s}, 0);
    @(negedge rclk);
    channel_busy = 1'b0;
    repeat (4) @(negedge rclk);

    // Reset during SEND abandons the frame; the next one is clean
    ack_en = 1'b1;
    send(8'h5A, t);
    repeat (3) @(negedge rclk);
    reset = 1'b1;
    @(posedge rclk);
    #1;
    check("midrst_serial", {31'd0, serial_out}, 0);
    check("midrst_tx_busy", {31'd0, tx_busy}, 0);
    @(negedge rclk);
    reset = 1'b0;
    send(8'h96, t);
    wait_idle();

    // item_valid toggling during the frame must not cause another accept
    send(8'hC3, t);
    item_in = 8'hFF;
    for (int k = 0; k < 12; k++) begin
      @(negedge rclk);
      item_valid = ~item_valid;
    end
    @(negedge rclk);
    item_valid = 1'b0;
    repeat (30) @(negedge rclk);
    check("toggle_idle", {31'd0, tx_busy}, 0);
    check("toggle_sb_empty", sb.size(), 0);

`ifdef DCLK_TX_STATS_EN
    do_reset();
    @(negedge rclk);
    check("stats_rst_frames", {16'd0, frames_sent}, 0);
    check("stats_rst_stall", {16'd0, stall_cycles}, 0);
    send(8'h11, t);
    send(8'h22, t);
    send(8'h33, t);
    wait_idle();
    repeat (10) @(negedge rclk);
    ack_en = 1'b0;
    channel_busy = 1'b1;
    repeat (4) @(negedge rclk);
    item_valid = 1'b1;
    repeat (10) @(negedge rclk);
    item_valid = 1'b0;
    check("stats_frames", {16'd0, frames_sent}, 3);
    check("stats_stall", {16'd0, stall_cycles}, 10);
    item_valid = 1'b1;
    repeat (65526) @(negedge rclk);
    item_valid = 1'b0;
    check("stats_stall_wrap", {16'd0, stall_cycles}, 0);
    channel_busy = 1'b0;
    repeat (4) @(negedge rclk);
`endif

    repeat (5) @(negedge rclk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
